// File: rtl/msgmii_pkg.sv
// Shared types and constants for the MSGMII/TBI reset sequencer.
// State encodings are visible through the status register, so keep them stable.
package msgmii_pkg;

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_SERDES_HOLD = 3'd2,
    ST_WAIT_RDY    = 3'd3,
    ST_CORE_HOLD   = 3'd4,
    ST_RUN         = 3'd5
  } state_e;

  localparam int unsigned DEF_LOCK_FILT   = 8;
  localparam int unsigned DEF_SERDES_HOLD = 64;
  localparam int unsigned DEF_RDY_TIMEOUT = 4096;
  localparam int unsigned DEF_CORE_HOLD   = 32;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/msgmii_sync_filt.sv
// Two-flop synchroniser with optional stability filter: the output only follows
// the synced input after it has differed for FILT consecutive cycles.
module msgmii_sync_filt
  import msgmii_pkg::*;
#(
  parameter int unsigned FILT = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  generate
    if (FILT == 0) begin : g_plain
      assign q_o = s2_q;
    end else begin : g_filt
      localparam int unsigned CW = clog2(FILT + 1);
      logic [CW-1:0] cnt_q, cnt_d;
      logic          ok_q, ok_d;

      // Counter runs only while synced input disagrees with the accepted value.
      always_comb begin
        cnt_d = '0;
        ok_d  = ok_q;
        if (s2_q != ok_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(FILT)) begin
            ok_d  = s2_q;
            cnt_d = '0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          cnt_q <= '0;
          ok_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          ok_q  <= ok_d;
        end
      end

      assign q_o = ok_q;
    end
  endgenerate

endmodule

// File: rtl/msgmii_rst_seq.sv
// Power-up / recovery reset sequencer for the MSGMII/TBI path: orders SerDes and
// core reset release against PLL lock and SerDes ready, and re-runs on loss.
module msgmii_rst_seq
  import msgmii_pkg::*;
#(
  parameter int unsigned LOCK_FILT   = DEF_LOCK_FILT,
  parameter int unsigned SERDES_HOLD = DEF_SERDES_HOLD,
  parameter int unsigned RDY_TIMEOUT = DEF_RDY_TIMEOUT,
  parameter int unsigned CORE_HOLD   = DEF_CORE_HOLD
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       serdes_rdy,
  input  logic       sw_rst,
  input  logic       test_bypass,
  output logic       serdes_rst,
  output logic       core_rst,
  output logic       seq_done,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int unsigned PH_W = clog2(max3(SERDES_HOLD, RDY_TIMEOUT, CORE_HOLD) + 1);
  localparam logic [PH_W-1:0] SH_LAST = PH_W'(SERDES_HOLD - 1);
  localparam logic [PH_W-1:0] RT_LAST = PH_W'(RDY_TIMEOUT - 1);
  localparam logic [PH_W-1:0] CH_LAST = PH_W'(CORE_HOLD - 1);

  logic lock_ok, rdy_s;

  msgmii_sync_filt #(.FILT(LOCK_FILT)) u_lock (
    .clk(clk), .resetn(resetn), .d_i(pll_lock), .q_o(lock_ok)
  );

  msgmii_sync_filt #(.FILT(0)) u_rdy (
    .clk(clk), .resetn(resetn), .d_i(serdes_rdy), .q_o(rdy_s)
  );

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [3:0]      retry_q, retry_d;
  logic            serdes_q, serdes_d;
  logic            core_q, core_d;
  logic            done_q, done_d;
  logic            timeout;

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      ST_RESET:       state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK:   if (lock_ok && !sw_rst) state_d = ST_SERDES_HOLD;
      ST_SERDES_HOLD: if (phase_q == SH_LAST) state_d = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (rdy_s) begin
          state_d = ST_CORE_HOLD;
        end else if (phase_q == RT_LAST) begin
          state_d = ST_SERDES_HOLD;
          timeout = 1'b1;
        end
      end
      ST_CORE_HOLD:   if (phase_q == CH_LAST) state_d = ST_RUN;
      ST_RUN:         state_d = ST_RUN;
      default:        state_d = ST_RESET;
    endcase

    // Lock loss / software request outrank ready loss.
    if (state_q inside {ST_SERDES_HOLD, ST_WAIT_RDY, ST_CORE_HOLD, ST_RUN}) begin
      if (!lock_ok || sw_rst) begin
        state_d = ST_WAIT_LOCK;
      end else if ((state_q inside {ST_CORE_HOLD, ST_RUN}) && !rdy_s) begin
        state_d = ST_SERDES_HOLD;
      end
    end

    retry_d = retry_q;
    if (timeout && state_d == ST_SERDES_HOLD && retry_q != 4'hF) retry_d = retry_q + 4'd1;

    if (state_d != state_q)   phase_d = '0;
    else if (phase_q == '1)   phase_d = phase_q;
    else                      phase_d = phase_q + 1'b1;

    // Outputs decoded from the next state so they move on the same edge.
    serdes_d = !(state_d inside {ST_WAIT_RDY, ST_CORE_HOLD, ST_RUN});
    core_d   = (state_d != ST_RUN);
    done_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_RESET;
      phase_q  <= '0;
      retry_q  <= '0;
      serdes_q <= 1'b1;
      core_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      retry_q  <= retry_d;
      serdes_q <= serdes_d;
      core_q   <= core_d;
      done_q   <= done_d;
    end
  end

  assign serdes_rst = serdes_q;
  assign core_rst   = test_bypass ? ~resetn : core_q;
  assign seq_done   = done_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule

// File: tb/tb_msgmii_rst_seq.sv
// Directed bench for msgmii_rst_seq: cycle-exact checks of power-up, glitch
// filtering, sw reset, retry saturation, ready loss and mid-sequence reset.
module tb_msgmii_rst_seq;

  localparam int unsigned RT = 512;
  localparam int unsigned SH = 64;

  logic       clk = 1'b0;
  logic       resetn, pll_lock, serdes_rdy, sw_rst, test_bypass;
  logic       serdes_rst, core_rst, seq_done;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  msgmii_rst_seq #(.RDY_TIMEOUT(RT)) dut (
    .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .serdes_rdy(serdes_rdy),
    .sw_rst(sw_rst), .test_bypass(test_bypass), .serdes_rst(serdes_rst),
    .core_rst(core_rst), .seq_done(seq_done), .retry_cnt(retry_cnt), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    int bad;
    int tk;
    resetn = 1'b0; pll_lock = 1'b0; serdes_rdy = 1'b0; sw_rst = 1'b0; test_bypass = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_serdes", 32'(serdes_rst), 32'd1);
    chk("rst_core", 32'(core_rst), 32'd1);
    chk("rst_done", 32'(seq_done), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    resetn = 1'b1;
    cyc = 0;

    // Power-up: lock at 10, accepted at 20, SerDes released at 85.
    step();
    chk("pu_waitlock", 32'(state), 32'd1);
    run_to(10); pll_lock = 1'b1;
    run_to(20); chk("pu_pre_hold", 32'(state), 32'd1);
    run_to(21); chk("pu_hold", 32'(state), 32'd2);
    run_to(84); chk("pu_serdes_hi", 32'(serdes_rst), 32'd1);
    run_to(85); chk("pu_serdes_lo", 32'(serdes_rst), 32'd0);
                chk("pu_waitrdy", 32'(state), 32'd3);
    run_to(105); serdes_rdy = 1'b1;
    run_to(108); chk("pu_corehold", 32'(state), 32'd4);
    run_to(139); chk("pu_core_hi", 32'(core_rst), 32'd1);
                 chk("pu_done_lo", 32'(seq_done), 32'd0);
    run_to(140); chk("pu_core_lo", 32'(core_rst), 32'd0);
                 chk("pu_done", 32'(seq_done), 32'd1);
                 chk("pu_run", 32'(state), 32'd5);

    // 5-cycle lock glitch is filtered out.
    run_to(150); pll_lock = 1'b0;
    run_to(155); pll_lock = 1'b1;
    bad = 0;
    while (cyc < 180) begin
      step();
      if (state != 3'd5 || core_rst != 1'b0 || serdes_rst != 1'b0) bad++;
    end
    chk("glitch5", 32'(bad), 32'd0);

    // 9-cycle lock glitch drops lock and re-runs the sequence.
    run_to(200); pll_lock = 1'b0;
    run_to(209); pll_lock = 1'b1;
    run_to(210); chk("g9_still_run", 32'(state), 32'd5);
    run_to(211); chk("g9_waitlock", 32'(state), 32'd1);
                 chk("g9_serdes", 32'(serdes_rst), 32'd1);
                 chk("g9_core", 32'(core_rst), 32'd1);
    run_to(220); chk("g9_hold", 32'(state), 32'd2);
    run_to(284); chk("g9_serdes_lo", 32'(serdes_rst), 32'd0);
    run_to(285); chk("g9_corehold", 32'(state), 32'd4);
    run_to(316); chk("g9_corehold_end", 32'(state), 32'd4);
    run_to(317); chk("g9_run", 32'(state), 32'd5);
                 chk("g9_core_lo", 32'(core_rst), 32'd0);

    // sw_rst pulse of 3 cycles: held in WAIT_LOCK, resumes one cycle after release.
    run_to(330); sw_rst = 1'b1;
    run_to(331); chk("sw_waitlock", 32'(state), 32'd1);
    run_to(333); chk("sw_held", 32'(state), 32'd1);
                 sw_rst = 1'b0;
    run_to(334); chk("sw_resume", 32'(state), 32'd2);
    bad = 0;
    while (cyc < 430) begin
      step();
      if (core_rst != 1'b1) bad++;
    end
    chk("sw_core_held", 32'(bad), 32'd0);
    run_to(431); chk("sw_run", 32'(state), 32'd5);

    // Ready never returns: retry every RT+SH cycles, saturating at 15.
    run_to(450); serdes_rdy = 1'b0;
    run_to(453); chk("rt_hold", 32'(state), 32'd2);
                 chk("rt_core", 32'(core_rst), 32'd1);
                 chk("rt_serdes", 32'(serdes_rst), 32'd1);
    tk = 453 + int'(RT + SH);
    run_to(tk - 1); chk("rt_pre1", 32'(retry_cnt), 32'd0);
                    chk("rt_pre1_st", 32'(state), 32'd3);
    run_to(tk);     chk("rt_cnt1", 32'(retry_cnt), 32'd1);
                    chk("rt_repulse", 32'(serdes_rst), 32'd1);
    run_to(tk + int'(SH) - 1); chk("rt_pulse_end", 32'(serdes_rst), 32'd1);
    run_to(tk + int'(SH));     chk("rt_pulse_off", 32'(serdes_rst), 32'd0);
    run_to(453 + 2 * int'(RT + SH)); chk("rt_cnt2", 32'(retry_cnt), 32'd2);
    tk = 453 + 15 * int'(RT + SH);
    run_to(tk - 1); chk("rt_cnt14", 32'(retry_cnt), 32'd14);
    run_to(tk);     chk("rt_cnt15", 32'(retry_cnt), 32'd15);
    tk = 453 + 16 * int'(RT + SH);
    run_to(tk);     chk("rt_sat", 32'(retry_cnt), 32'd15);
                    chk("rt_sat_st", 32'(state), 32'd2);
    run_to(tk + 10); serdes_rdy = 1'b1;
    run_to(tk + 65); chk("rt_recover_ch", 32'(state), 32'd4);
    run_to(tk + 97); chk("rt_recover_run", 32'(state), 32'd5);

    // Ready drop in RUN, then a one-cycle resetn mid CORE_HOLD with bypass.
    tk = tk + 134;
    run_to(tk);      serdes_rdy = 1'b0;
    run_to(tk + 3);  chk("rd_hold", 32'(state), 32'd2);
                     chk("rd_core", 32'(core_rst), 32'd1);
                     chk("rd_serdes", 32'(serdes_rst), 32'd1);
    run_to(tk + 10); serdes_rdy = 1'b1;
    run_to(tk + 66); chk("rd_serdes_hi", 32'(serdes_rst), 32'd1);
    run_to(tk + 67); chk("rd_serdes_lo", 32'(serdes_rst), 32'd0);
    run_to(tk + 68); chk("rd_corehold", 32'(state), 32'd4);
    run_to(tk + 80); chk("rd_retry_kept", 32'(retry_cnt), 32'd15);
    resetn = 1'b0; test_bypass = 1'b1;
    #1;              chk("byp_assert", 32'(core_rst), 32'd1);
    run_to(tk + 81); chk("mr_state", 32'(state), 32'd0);
                     chk("mr_serdes", 32'(serdes_rst), 32'd1);
                     chk("mr_done", 32'(seq_done), 32'd0);
                     chk("mr_retry", 32'(retry_cnt), 32'd0);
    resetn = 1'b1;
    #1;              chk("byp_release", 32'(core_rst), 32'd0);
    test_bypass = 1'b0;
    #1;              chk("byp_off_core", 32'(core_rst), 32'd1);
    run_to(tk + 82); chk("mr_waitlock", 32'(state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
